lemmings_dig_arbiter: RTL
=========================

# lemmings_dig_arbiter

Shares a single shovel among N lemming walker FSMs, so at most one lemming digs at any time. Each lemming controller raises a dig request. The arbiter grants the shovel round-robin by driving that lemming's `dig` input, then holds the grant until the lemming finishes digging or fails to start. It sits between the level/player input logic and the array of per-lemming FSMs.

## Interface
- `N`, 4: number of lemmings (2..8).
- `ACK_WAIT`, 3: cycles a grant may stay unacknowledged before it is withdrawn (1..15).
- `clk`  in  1: rising-edge clock.
- `areset`  in  1: asynchronous, active-high reset.
- `dig_req`  in  N: level request per lemming; may drop at any time.
- `digging`  in  N: per-lemming `digging` status output.
- `dig_gnt`  out  N: one-hot or zero; drives each lemming's `dig` input; registered.
- `owner`  out  3: index of the current/last grantee; valid while `busy`.
- `busy`  out  1: shovel allocated (state GRANT or HOLD).
- `timeout`  out  1: one-cycle pulse when a grant expires unacknowledged.
- `grant_count`  out  8: number of acknowledged grants; saturates at 255.

## Operation
- States: IDLE, GRANT, HOLD, RELEASE.
- IDLE
  - If any `dig_req` is set, pick the first set bit at or after `ptr` (wrapping modulo N).
  - Then: `owner` <= pick, `dig_gnt[pick]` <= 1, `wait_cnt` <= 0, go to GRANT.
  - If no request is set, stay in IDLE.
- GRANT (`dig_gnt[owner]` held high):
  - If `digging[owner]` = 1: `dig_gnt` <= 0, `grant_count`++ (saturating), go to HOLD.
  - Else if `dig_req[owner]` = 0: `dig_gnt` <= 0, go to RELEASE (request withdrawn).
  - Else if `wait_cnt` = ACK_WAIT-1: `dig_gnt` <= 0, `timeout` <= 1, go to RELEASE.
  - Else `wait_cnt`++.
- HOLD
  - Stay while `digging[owner]` = 1; go to RELEASE when it falls (the lemming fell through).
  - `dig_req` is ignored in this state.
- RELEASE: `ptr` <= (owner+1) mod N, go to IDLE. This state gives one guaranteed idle cycle between owners.
- Priority
  - Acknowledge outranks withdrawal, and withdrawal outranks timeout, when they happen in the same cycle.
  - `digging` bits from non-owners are ignored. They cannot occur legally, since no other lemming holds a grant.
- `wait_cnt`: 4 bits; `ptr`: 3 bits; both are internal registers.

## Timing
- Reset (async assert, registers sample on the first `clk` edge after deassert):
  - state = IDLE, `ptr` = 0, `owner` = 0.
  - `dig_gnt` = 0, `busy` = 0, `timeout` = 0, `grant_count` = 0.
- Request to grant: `dig_req` sampled high at edge k gives `dig_gnt` high after edge k.
- Typical acknowledge: the lemming sees `dig` at edge k+1 and `digging` rises after k+1. The arbiter samples it at edge k+2 and drops `dig_gnt` after k+2. The grant is therefore high for 2 cycles.
- Timeout: if no acknowledge arrives, `dig_gnt` stays high exactly ACK_WAIT cycles. `timeout` pulses for 1 cycle, coincident with the first cycle of RELEASE.
- Back-to-back: from the cycle `digging[owner]` falls to the next grant takes 3 edges: HOLD→RELEASE, RELEASE→IDLE, IDLE→GRANT.
- `busy` = (state == GRANT or HOLD), combinational from the state register.
- Mid-operation `areset`: `dig_gnt` clears immediately (async), and no count or pointer update is kept.

## Structure
- Shared package `lemmings_pkg` holds:
  - the state encoding constants (IDLE=0, GRANT=1, HOLD=2, RELEASE=3);
  - the default N.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req[N-1:0]`, `ptr`.
  - Outputs: `idx`, `valid`.
  - Reused by any future shared-resource arbiter (e.g. exit gate, builder tool).
- Top level holds the FSM, `wait_cnt`, `ptr` and `grant_count`, and registers `dig_gnt` and `timeout`.

## Test plan
- Single requester: N=4, `dig_req`=0b0100. The lemming model asserts `digging` 1 cycle after `dig` and holds it 10 cycles. Required:
  - `dig_gnt`=0b0100 for 2 cycles, then `owner`=2, `busy` for 12 cycles;
  - `grant_count`=1, `ptr`=3.
- Round-robin fairness: all 4 request continuously, each dig lasts 5 cycles. Grant order must be 0,1,2,3,0, with a 3-cycle gap between the fall of `digging` and the next grant.
- Timeout: `dig_req`=0b0010 and the lemming never digs (falling), ACK_WAIT=3. Required:
  - `dig_gnt[1]` high exactly 3 cycles;
  - `timeout` pulses once;
  - `grant_count` stays 0 and `ptr`=2.
- Withdrawal in the same cycle as timeout: `dig_req[1]` drops on the last GRANT cycle. Required: RELEASE with no `timeout` pulse.
- Saturation: 300 acknowledged grants leave `grant_count`=255.
- Async reset: assert `areset` mid-HOLD, asynchronous to `clk`. Required:
  - `dig_gnt`, `busy`, `grant_count` clear with no clock edge;
  - after release, the first grant goes to the lowest set request starting from index 0.

Source files
------------

// File: rtl/lemmings_dig_arbiter_pkg.sv
// Shared definitions for the lemming shared-resource arbiters.
package lemmings_pkg;

  localparam int unsigned DEFAULT_N = 4;
  localparam int unsigned IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } dig_state_e;

endpackage

// File: rtl/lemmings_dig_arbiter_if.sv
// Request/grant bundle between the lemming FSM array and the shovel arbiter.
interface lemmings_dig_arbiter_if
  import lemmings_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
);

  logic [N-1:0]     dig_req;
  logic [N-1:0]     digging;
  logic [N-1:0]     dig_gnt;
  logic [IDX_W-1:0] owner;
  logic             busy;
  logic             timeout;
  logic [7:0]       grant_count;

  modport master (
    output dig_req, digging,
    input  dig_gnt, owner, busy, timeout, grant_count
  );

  modport slave (
    input  dig_req, digging,
    output dig_gnt, owner, busy, timeout, grant_count
  );

endinterface

// File: rtl/lemmings_dig_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick
  import lemmings_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [N-1:0] rot;
  int unsigned  hit;
  int unsigned  sum;

  // Rotate so ptr lands at bit 0, then find the lowest set bit of the rotated vector.
  always_comb begin
    rot   = N'({req, req} >> ptr);
    valid = 1'b0;
    hit   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!valid && rot[0]) begin
        valid = 1'b1;
        hit   = k;
      end
      rot = rot >> 1;
    end
    sum = 32'(ptr) + hit;
    if (sum >= N) begin
      sum = sum - N;
    end
    idx = IDX_W'(sum);
  end

endmodule

// File: rtl/lemmings_dig_arbiter.sv
// Round-robin shovel arbiter: grants one lemming at a time and holds the grant until it finishes digging.
module lemmings_dig_arbiter
  import lemmings_pkg::*;
#(
  parameter int unsigned N        = DEFAULT_N,
  parameter int unsigned ACK_WAIT = 3
) (
  input  logic                 clk,
  input  logic                 areset,
  lemmings_dig_arbiter_if.slave bus
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  dig_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [3:0]       wait_q, wait_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             to_q, to_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic [N-1:0]     own_mask;
  logic             own_digging;
  logic             own_req;

  rr_pick #(.N(N)) u_pick (
    .req   (bus.dig_req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Only the owner's status matters; stray digging bits from other lemmings are masked off.
  assign own_mask    = ONE << owner_q;
  assign own_digging = |(bus.digging & own_mask);
  assign own_req     = |(bus.dig_req & own_mask);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      wait_q  <= '0;
      gnt_q   <= '0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      wait_q  <= wait_d;
      gnt_q   <= gnt_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    wait_d  = wait_q;
    gnt_d   = gnt_q;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          gnt_d   = ONE << pick_idx;
          wait_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Acknowledge beats withdrawal, which beats timeout.
        if (own_digging) begin
          gnt_d   = '0;
          cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          state_d = HOLD;
        end else if (!own_req) begin
          gnt_d   = '0;
          state_d = RELEASE;
        end else if (wait_q == 4'(ACK_WAIT - 1)) begin
          gnt_d   = '0;
          to_d    = 1'b1;
          state_d = RELEASE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      HOLD: begin
        if (!own_digging) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        ptr_d   = (owner_q == IDX_W'(N - 1)) ? '0 : owner_q + IDX_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dig_gnt     = gnt_q;
  assign bus.owner       = owner_q;
  assign bus.busy        = (state_q == GRANT) || (state_q == HOLD);
  assign bus.timeout     = to_q;
  assign bus.grant_count = cnt_q;

endmodule
